// File: rtl/cic_decimator.sv
// N-stage CIC decimator: gated integrators, power-of-two phase counter,
// M-delay comb pipeline with a travelling valid bit, floor-truncated output.
module cic_decimator #(
   parameter int IN_WIDTH   = 8,
   parameter int OUT_WIDTH  = 8,
   parameter int STAGES     = 4,
   parameter int RATE       = 16,
   parameter int DIFF_DELAY = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [IN_WIDTH-1:0]  x_in,
   output logic                 out_valid,
   output logic [OUT_WIDTH-1:0] y_out
);

   localparam int PW    = $clog2(RATE);
   localparam int W     = IN_WIDTH + STAGES * $clog2(RATE * DIFF_DELAY);
   localparam int SHIFT = W - OUT_WIDTH;

   logic [W-1:0]  acc      [STAGES];
   logic [PW-1:0] phase;
   logic          capture;

   logic [W-1:0]  comb_in  [STAGES];
   logic          comb_v   [STAGES];
   logic [W-1:0]  dly      [STAGES][DIFF_DELAY];
   logic [W-1:0]  comb_out [STAGES];

   logic [W-1:0]        x_ext;
   logic signed [W-1:0] comb_last;

   assign x_ext     = {{(W - IN_WIDTH){x_in[IN_WIDTH-1]}}, x_in};
   assign comb_last = comb_out[STAGES-1];

   always_comb begin
      for (int unsigned j = 0; j < STAGES; j++) begin
         comb_out[j] = comb_in[j] - dly[j][DIFF_DELAY-1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            acc[k]     <= '0;
            comb_in[k] <= '0;
            comb_v[k]  <= 1'b0;
            for (int unsigned i = 0; i < DIFF_DELAY; i++) begin
               dly[k][i] <= '0;
            end
         end
         phase     <= '0;
         capture   <= 1'b0;
         out_valid <= 1'b0;
         y_out     <= '0;
      end else begin
         // Integrators read pre-edge values, so the chain adds N-1 sample delays.
         if (in_valid) begin
            acc[0] <= acc[0] + x_ext;
            for (int unsigned k = 1; k < STAGES; k++) begin
               acc[k] <= acc[k] + acc[k-1];
            end
            phase <= phase + PW'(1);
         end
         capture <= in_valid && (phase == PW'(RATE - 1));

         comb_v[0] <= capture;
         if (capture) begin
            comb_in[0] <= acc[STAGES-1];
         end
         for (int unsigned j = 1; j < STAGES; j++) begin
            comb_v[j] <= comb_v[j-1];
            if (comb_v[j-1]) begin
               comb_in[j] <= comb_out[j-1];
            end
         end

         for (int unsigned j = 0; j < STAGES; j++) begin
            if (comb_v[j]) begin
               dly[j][0] <= comb_in[j];
               for (int unsigned i = 1; i < DIFF_DELAY; i++) begin
                  dly[j][i] <= dly[j][i-1];
               end
            end
         end

         out_valid <= comb_v[STAGES-1];
         if (comb_v[STAGES-1]) begin
            y_out <= OUT_WIDTH'(comb_last >>> SHIFT);
         end
      end
   end

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: a frame-level CIC reference model
// predicts value and strobe cycle of every output; a second instance checks an alternate config.
module tb_cic_decimator;

   localparam int IW = 8;
   localparam int OW = 8;
   localparam int N  = 4;
   localparam int R  = 16;
   localparam int M  = 1;
   localparam int W  = IW + N * $clog2(R * M);
   localparam longint MASK = (longint'(1) << W) - 1;

   logic          clock = 1'b0;
   logic          reset, in_valid;
   logic [IW-1:0] x_in;
   logic          out_valid;
   logic [OW-1:0] y_out;

   logic          reset2, in_valid2;
   logic [7:0]    x2;
   logic          out_valid2;
   logic [7:0]    y2;

   cic_decimator #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .STAGES(N), .RATE(R), .DIFF_DELAY(M)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .x_in(x_in),
      .out_valid(out_valid), .y_out(y_out));

   cic_decimator #(.IN_WIDTH(8), .OUT_WIDTH(8), .STAGES(3), .RATE(8), .DIFF_DELAY(2)) dut_alt (
      .clock(clock), .reset(reset2), .in_valid(in_valid2), .x_in(x2),
      .out_valid(out_valid2), .y_out(y2));

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct { longint value; int cycle; } exp_t;
   exp_t sbq[$];
   exp_t e;

   int checks = 0;
   int failures = 0;

   longint m_acc [8];
   longint m_hist[8][2];
   int     m_phase;

   task automatic chk(input string tag, input longint obs, input longint expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < 8; k++) begin
         m_acc[k] = 0;
         m_hist[k][0] = 0;
         m_hist[k][1] = 0;
      end
      m_phase = 0;
   endfunction

   // One accepted sample; on the R-th sample of a frame run the combs at the low rate.
   function automatic void model_sample(input logic [IW-1:0] x, input int edge_idx);
      longint v, d, s;
      exp_t   ne;
      for (int k = N - 1; k >= 1; k--) m_acc[k] = (m_acc[k] + m_acc[k-1]) & MASK;
      m_acc[0] = (m_acc[0] + longint'($signed(x))) & MASK;
      if (m_phase == R - 1) begin
         v = m_acc[N-1];
         for (int j = 0; j < N; j++) begin
            d = m_hist[j][M-1];
            for (int i = M - 1; i >= 1; i--) m_hist[j][i] = m_hist[j][i-1];
            m_hist[j][0] = v;
            v = (v - d) & MASK;
         end
         s = (v << (64 - W)) >>> (64 - W);
         ne.value = s >>> (W - OW);
         ne.cycle = edge_idx + N + 1;
         sbq.push_back(ne);
      end
      m_phase = (m_phase + 1) % R;
   endfunction

   task automatic tick(input logic rst, input logic v, input logic [IW-1:0] x);
      @(negedge clock);
      reset = rst; in_valid = v; x_in = x;
      if (rst) begin
         model_reset();
         sbq.delete();
      end else if (v) begin
         model_sample(x, cyc + 1);
      end
   endtask

   longint last_y = 0;
   always @(posedge clock) begin
      #1;
      if (out_valid === 1'b1) begin
         checks++;
         assert (sbq.size() != 0) else begin
            failures++;
            $error("FAIL spurious_out observed=%0d expected=no_strobe", $signed(y_out));
         end
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("out_value", longint'($signed(y_out)), e.value);
            chk("out_cycle", longint'(cyc), longint'(e.cycle));
         end
         last_y = longint'($signed(y_out));
      end else if (sbq.size() != 0 && sbq[0].cycle <= cyc) begin
         checks++;
         failures++;
         $error("FAIL missing_out observed=no_strobe expected=%0d at cycle %0d", sbq[0].value, sbq[0].cycle);
         void'(sbq.pop_front());
      end
   end

   int alt_cnt = 0;
   int alt_last = 0;
   int alt_rel = 0;
   always @(posedge clock) begin
      #1;
      if (out_valid2 === 1'b1) begin
         if (alt_cnt == 0) chk("alt_first_cycle", longint'(cyc), longint'(alt_rel + 12));
         else              chk("alt_interval", longint'(cyc - alt_last), 8);
         if (alt_cnt >= 12) chk("alt_settled", longint'($signed(y2)), -7);
         alt_cnt++;
         alt_last = cyc;
      end
   end

   initial begin
      reset = 1'b1; in_valid = 1'b1; x_in = 8'd5;
      reset2 = 1'b1; in_valid2 = 1'b1; x2 = 8'hF9;
      model_reset();

      // Reset held with valid input: nothing accepted, outputs stay zero.
      repeat (3) begin
         tick(1'b1, 1'b1, 8'd5);
         @(posedge clock); #1;
         chk("reset_out_valid", longint'(out_valid), 0);
         chk("reset_y_out", longint'(y_out), 0);
      end
      reset2 = 1'b0;
      alt_rel = cyc;

      // DC step
      repeat (R * 12) tick(1'b0, 1'b1, 8'd10);
      chk("dc_settled", last_y, 10);

      // Full-scale extremes
      repeat (R * 200) tick(1'b0, 1'b1, 8'd127);
      chk("pos_full_scale", last_y, 127);
      repeat (R * 200) tick(1'b0, 1'b1, 8'h80);
      chk("neg_full_scale", last_y, -128);

      // Gapped input, one accepted sample in three
      tick(1'b1, 1'b0, 8'd0);
      for (int i = 0; i < R * 12 * 3; i++) tick(1'b0, (i % 3) == 0, 8'd10);
      repeat (10) tick(1'b0, 1'b0, 8'd0);
      chk("gapped_settled", last_y, 10);
      chk("gapped_drained", longint'(sbq.size()), 0);

      // Reset mid-run, asserted while in_valid=1
      tick(1'b1, 1'b0, 8'd0);
      repeat (40) tick(1'b0, 1'b1, 8'd10);
      tick(1'b1, 1'b1, 8'd10);
      @(posedge clock); #1;
      chk("post_reset_quiet", longint'(out_valid), 0);
      repeat (4) begin
         tick(1'b0, 1'b0, 8'd0);
         @(posedge clock); #1;
         chk("post_reset_quiet", longint'(out_valid), 0);
      end
      repeat (R * 8) tick(1'b0, 1'b1, 8'd10);
      repeat (10) tick(1'b0, 1'b0, 8'd0);
      chk("restart_settled", last_y, 10);
      chk("restart_drained", longint'(sbq.size()), 0);

      checks++;
      assert (alt_cnt > 100) else begin
         failures++;
         $error("FAIL alt_strobe_count observed=%0d expected=>100", alt_cnt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
